// File: rtl/ldm_wb_seq_if.sv
// Bus bundle for the load-multiple writeback sequencer.
// Carries the request, the memory read handshake and the register-file
// write port. The master side issues requests and returns memory data.
// The slave side is the sequencer itself.
interface ldm_wb_seq_if;
  // request
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic [3:0]  base_reg;
  logic        up;
  logic        wb_en;
  // memory read handshake
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] addr;
  // register-file write port and status
  logic [31:0] PW;
  logic [3:0]  C;
  logic        RFLd;
  logic        pc_wr;
  logic        busy;
  logic        done;

  modport master (
    output start, reg_list, base, base_reg, up, wb_en, mem_valid, mem_data,
    input  mem_ready, addr, PW, C, RFLd, pc_wr, busy, done
  );

  modport slave (
    input  start, reg_list, base, base_reg, up, wb_en, mem_valid, mem_data,
    output mem_ready, addr, PW, C, RFLd, pc_wr, busy, done
  );
endinterface

// File: rtl/ldm_wb_seq.sv
// Load-multiple writeback sequencer.
// Walks a 16-bit register bitmap lowest index first. It requests one word
// per set bit, writes each accepted word into the register file one cycle
// later, and then optionally writes the updated base register back.
// Optional feature: define LDM_PC_WRITE_EN to honour bit 15 (R15/PC) of the
// list and to drive pc_wr. Without it, bit 15 is dropped when the request
// is latched and pc_wr is tied low.
module ldm_wb_seq (
  input  logic        CLK,
  input  logic        RST,
  ldm_wb_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WBASE = 2'd2,
    FIN   = 2'd3
  } state_t;

`ifdef LDM_PC_WRITE_EN
  localparam logic [15:0] LIST_MASK = 16'hFFFF;
`else
  localparam logic [15:0] LIST_MASK = 16'h7FFF;
`endif

  // Number of set bits in a register list (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; 0 when the list is empty.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t      state;
  state_t      state_nxt;

  // latched request
  logic [15:0] list_q;       // registers still to be loaded
  logic [3:0]  base_reg_q;
  logic        wb_need_q;    // base writeback still wanted after the loads
  logic [31:0] wb_val_q;     // updated base value

  // registered outputs
  logic [31:0] addr_q;
  logic [31:0] pw_q;
  logic [3:0]  c_q;
  logic        rfld_q;

  // combinational outputs
  logic        mem_ready_c;
  logic        busy_c;
  logic        done_c;

  // request decode, used only while IDLE
  logic [15:0] list_in;
  logic [4:0]  n_in;
  logic [31:0] span_in;
  logic [31:0] addr_first_in;
  logic [31:0] wb_val_in;
  logic        wb_need_in;

  // load walk
  logic        accept;
  logic [3:0]  cur_idx;
  logic        last_word;

  assign list_in       = bus.reg_list & LIST_MASK;
  assign n_in          = popcount16(list_in);
  assign span_in       = {25'd0, n_in, 2'b00};
  assign addr_first_in = bus.up ? bus.base : bus.base - span_in;
  assign wb_val_in     = bus.up ? bus.base + span_in : bus.base - span_in;
  // A loaded base register wins over the writeback value.
  assign wb_need_in    = bus.wb_en & ~list_in[bus.base_reg];

  assign accept    = mem_ready_c & bus.mem_valid;
  assign cur_idx   = lowest_set(list_q);
  // Only one bit left means the word being accepted is the final one.
  assign last_word = (list_q & (list_q - 16'd1)) == 16'd0;

  // State register.
  // NOTE: clocked processes use non-blocking assignments only, so every
  // flop samples values from before the edge regardless of process order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and the state-derived handshake/status outputs.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    mem_ready_c = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          if (n_in == 5'd0) state_nxt = wb_need_in ? WBASE : FIN;
          else              state_nxt = LOAD;
        end
      end
      LOAD: begin
        mem_ready_c = 1'b1;
        if (bus.mem_valid && last_word) state_nxt = wb_need_q ? WBASE : FIN;
      end
      WBASE: state_nxt = FIN;
      FIN: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, address walk and register-file write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      list_q     <= '0;
      base_reg_q <= '0;
      wb_need_q  <= 1'b0;
      wb_val_q   <= '0;
      addr_q     <= '0;
      pw_q       <= '0;
      c_q        <= '0;
      rfld_q     <= 1'b0;
    end else begin
      rfld_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            list_q     <= list_in;
            base_reg_q <= bus.base_reg;
            wb_need_q  <= wb_need_in;
            wb_val_q   <= wb_val_in;
            addr_q     <= addr_first_in;
          end
        end
        LOAD: begin
          if (accept) begin
            rfld_q <= 1'b1;
            c_q    <= cur_idx;
            pw_q   <= bus.mem_data;
            list_q <= list_q & (list_q - 16'd1);
            addr_q <= addr_q + 32'd4;
          end
        end
        WBASE: begin
          rfld_q <= 1'b1;
          c_q    <= base_reg_q;
          pw_q   <= wb_val_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_ready = mem_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.addr      = addr_q;
  assign bus.PW        = pw_q;
  assign bus.C         = c_q;
  assign bus.RFLd      = rfld_q;

`ifdef LDM_PC_WRITE_EN
  assign bus.pc_wr = rfld_q & (c_q == 4'd15);
`else
  assign bus.pc_wr = 1'b0;
`endif

endmodule
